rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (regwrite/ad3/wd3) between two writeback requesters: the ALU result path and the memory-load path.
- Arbitrates round-robin and registers the winning write onto the register file write port.
- Keeps a 32-entry pending-write scoreboard, so issue logic can detect RAW hazards on regop1/regop2 reads.
- Sits between the execute/memory stages and the register file.

Parameters:
- DW, 32, data width of writeback data and wd3.
- AW, 5, register address width; the register count is 2**AW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- hold  in  1  write-port freeze; while high, no grants are made.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_rd  in  AW  load destination register.
- mem_data  in  DW  load data.
- iss_valid  in  1  instruction issued with a destination register.
- iss_rd  in  AW  destination of the issued instruction.
- regwrite  out  1  register file write enable.
- ad3  out  AW  register file write address.
- wd3  out  DW  register file write data.
- pending  out  2**AW  scoreboard; bit r high means a write to r is outstanding.
- sb_err  out  1  sticky error flag: a writeback arrived for a non-pending register.

Behaviour:
- Reset (rst high at a clk edge):
  - regwrite=0, ad3=0, wd3=0, pending=0, sb_err=0.
  - Round-robin pointer last=MEM, so the ALU wins the first contention.
  - Reset overrides any request or issue presented in the same cycle; such requests are not accepted.
- Grant logic, combinational from the current inputs and state:
  - hold=1: alu_ready=mem_ready=0.
  - hold=0, only one requester valid: that requester's ready=1.
  - hold=0, both valid: ready=1 for the requester that is not `last`; the other requester's ready=0.
  - ready never asserts without the matching valid.
- Transfer: valid&ready at a clk edge. At most one transfer per cycle.
- Pointer update: on every transfer, last := the granted requester. last is unchanged in cycles with no transfer.
- Output stage, registered, 1-cycle latency:
  - A transfer at edge N drives regwrite=1, ad3=rd, wd3=data during cycle N+1.
  - With no transfer, regwrite=0 and ad3/wd3 hold their previous values.
  - Back-to-back transfers give a continuous regwrite=1 stream.
- Register x0:
  - A transfer with rd=0 is accepted (ready as normal), but regwrite stays 0 for it.
  - iss_valid with iss_rd=0 never sets pending[0]; pending[0] is always 0.
- Requester obligations (not checked by this block): once valid is high, rd and data stay stable until the transfer.
- Scoreboard, updated at the clk edge:
  - iss_valid with iss_rd≠0 sets pending[iss_rd].
  - A transfer with rd≠0 clears pending[rd].
  - Set and clear of the same register in the same cycle: set wins, because a new issue follows the old writeback.
  - Issue to an already pending register leaves the bit at 1. No counting; issue logic must stall such issues.
- sb_err:
  - Set when a transfer with rd≠0 finds pending[rd]=0 and no same-cycle set of that register.
  - Stays set until rst.
- hold mid-stream: a write registered before hold rose still appears on the write port in the next cycle. Later writes are only delayed, never dropped.

Optional Feature:
- Macro: RF_WB_FORWARD_EN.
- When defined, adds ports:
  - rd_ad1, rd_ad2  in  AW  read addresses.
  - fwd1_hit, fwd2_hit  out  1  forward-select flags.
  - fwd1_data, fwd2_data  out  DW  forwarded data.
- fwdN_hit=1 when regwrite=1, ad3=rd_adN and rd_adN≠0.
- fwdN_data=wd3, combinational. This covers the same-cycle write-then-read case that the register file's registered write misses.
- When fwdN_hit=0, fwdN_data=0.
- When the macro is undefined, these ports do not exist and there is no forwarding logic.

Test Plan:
- Reset with both requesters valid: after rst, alu_valid=1 rd=3 data=0xAAAA0001 and mem_valid=1 rd=4 data=0xBBBB0002 held high. Required: ALU granted first; cycle+1 regwrite=1 ad3=3 wd3=0xAAAA0001; then mem granted, ad3=4 wd3=0xBBBB0002; then ALU again (strict alternation).
- Single requester streaming: mem_valid held high for 4 cycles, rd=5..8. Required: 4 consecutive regwrite pulses with ad3=5,6,7,8 and no bubbles.
- hold: hold=1 for 3 cycles with alu_valid=1 rd=9. Required: alu_ready=0 and regwrite=0 during hold; grant in the cycle hold drops; write of reg 9 one cycle later.
- x0 write: alu rd=0 data=0xFFFFFFFF. Required: alu_ready=1, regwrite stays 0, pending[0]=0, sb_err=0.
- Scoreboard: iss_rd=12, then an ALU transfer rd=12 in the same cycle as iss_rd=12 reissue. Required: pending[12]=1 throughout. A later mem transfer rd=12 clears it. A further transfer rd=12 with no issue sets sb_err=1, which stays 1 until rst.
- With RF_WB_FORWARD_EN: write of reg 7 data 0x1234 in flight, rd_ad1=7, rd_ad2=0. Required: during the regwrite cycle fwd1_hit=1, fwd1_data=0x1234, fwd2_hit=0.

Source files
------------

// File: rtl/rf_wb_if.sv
// ---------------------------------------------------------------------------
// rf_wb_if -- writeback bus between the execute/memory stages, the issue
// stage and the register file write port.
//
// Signals
//   hold                 write-port freeze (no grants while high)
//   alu_valid/ready/rd/data   ALU writeback request channel
//   mem_valid/ready/rd/data   load writeback request channel
//   iss_valid, iss_rd    issued instruction with a destination register
//   regwrite, ad3, wd3   register file write port (registered)
//   pending              per-register outstanding-write scoreboard
//   sb_err               sticky "writeback to a non-pending register" flag
//
// Modports
//   master : pipeline side (drives requests, issue and hold)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface rf_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic               hold;
  logic               alu_valid;
  logic               alu_ready;
  logic [AW-1:0]      alu_rd;
  logic [DW-1:0]      alu_data;
  logic               mem_valid;
  logic               mem_ready;
  logic [AW-1:0]      mem_rd;
  logic [DW-1:0]      mem_data;
  logic               iss_valid;
  logic [AW-1:0]      iss_rd;
  logic               regwrite;
  logic [AW-1:0]      ad3;
  logic [DW-1:0]      wd3;
  logic [2**AW-1:0]   pending;
  logic               sb_err;

  modport master (
    output hold,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output iss_valid, iss_rd,
    input  regwrite, ad3, wd3, pending, sb_err
  );

  modport slave (
    input  hold,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  iss_valid, iss_rd,
    output regwrite, ad3, wd3, pending, sb_err
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter -- shares the register file's single write port between the
// ALU result path and the memory-load path.
//
// * Round-robin arbitration between the two requesters; the requester that
//   did not win last time gets priority on contention. After reset the
//   pointer says "last = MEM", so the ALU wins the first contention.
// * The winning write is registered onto regwrite/ad3/wd3 (1-cycle latency).
//   Writes to x0 are accepted but never produce a regwrite pulse.
// * A pending-write scoreboard (one bit per register) is set on issue and
//   cleared on writeback; a same-cycle issue of the register wins over the
//   clear. sb_err is a sticky flag for a writeback to a non-pending register.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   bus        rf_wb_if.slave (requests, issue, write port, scoreboard)
//
// Optional feature (macro RF_WB_FORWARD_EN):
//   rd_ad1, rd_ad2       in   read addresses
//   fwd1_hit, fwd2_hit   out  write-port value matches the read address
//   fwd1_data, fwd2_data out  forwarded wd3 (0 when no hit)
// Covers the read of a register in the same cycle it is being written.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_if.slave        bus
`ifdef RF_WB_FORWARD_EN
  ,
  input  logic [AW-1:0] rd_ad1,
  input  logic [AW-1:0] rd_ad2,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd1_data,
  output logic [DW-1:0] fwd2_data
`endif
);

  localparam int NREG = 2**AW;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // State
  req_e             last_q, last_d;
  logic             regwrite_q, regwrite_d;
  logic [AW-1:0]    ad3_q, ad3_d;
  logic [DW-1:0]    wd3_q, wd3_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic             sb_err_q, sb_err_d;

  // Grant / transfer decode
  logic             alu_gnt;
  logic             mem_gnt;
  logic             xfer;
  logic [AW-1:0]    x_rd;
  logic [DW-1:0]    x_data;
  logic             iss_set;

  // -------------------------------------------------------------------------
  // Grant logic. Readies are gated with rst so that nothing presented during
  // reset is reported as accepted.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a signal unassigned would infer a latch.
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!rst && !bus.hold) begin
      if (bus.alu_valid && bus.mem_valid) begin
        if (last_q == REQ_MEM) alu_gnt = 1'b1;
        else                   mem_gnt = 1'b1;
      end else begin
        alu_gnt = bus.alu_valid;
        mem_gnt = bus.mem_valid;
      end
    end
  end

  assign xfer    = alu_gnt | mem_gnt;
  assign x_rd    = mem_gnt ? bus.mem_rd   : bus.alu_rd;
  assign x_data  = mem_gnt ? bus.mem_data : bus.alu_data;
  assign iss_set = bus.iss_valid && (bus.iss_rd != '0);

  // -------------------------------------------------------------------------
  // Next-state: pointer, output stage, scoreboard, error flag.
  // -------------------------------------------------------------------------
  always_comb begin
    last_d     = last_q;
    regwrite_d = 1'b0;
    ad3_d      = ad3_q;
    wd3_d      = wd3_q;
    pending_d  = pending_q;
    sb_err_d   = sb_err_q;

    if (xfer) begin
      last_d = mem_gnt ? REQ_MEM : REQ_ALU;
    end

    // x0 transfers are consumed here without touching the write port.
    if (xfer && (x_rd != '0)) begin
      regwrite_d = 1'b1;
      ad3_d      = x_rd;
      wd3_d      = x_data;
      if (!pending_q[x_rd] && !(iss_set && (bus.iss_rd == x_rd))) begin
        sb_err_d = 1'b1;
      end
      pending_d[x_rd] = 1'b0;
    end

    // Issue is applied after the clear: a new issue follows the old
    // writeback, so set wins on the same register.
    if (iss_set) begin
      pending_d[bus.iss_rd] = 1'b1;
    end

    pending_d[0] = 1'b0;
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      last_q     <= REQ_MEM;
      regwrite_q <= 1'b0;
      ad3_q      <= '0;
      wd3_q      <= '0;
      pending_q  <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      last_q     <= last_d;
      regwrite_q <= regwrite_d;
      ad3_q      <= ad3_d;
      wd3_q      <= wd3_d;
      pending_q  <= pending_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.regwrite  = regwrite_q;
  assign bus.ad3       = ad3_q;
  assign bus.wd3       = wd3_q;
  assign bus.pending   = pending_q;
  assign bus.sb_err    = sb_err_q;

`ifdef RF_WB_FORWARD_EN
  // -------------------------------------------------------------------------
  // Forwarding of the value currently on the write port.
  // -------------------------------------------------------------------------
  always_comb begin
    fwd1_hit  = regwrite_q && (ad3_q == rd_ad1) && (rd_ad1 != '0);
    fwd2_hit  = regwrite_q && (ad3_q == rd_ad2) && (rd_ad2 != '0);
    fwd1_data = fwd1_hit ? wd3_q : '0;
    fwd2_data = fwd2_hit ? wd3_q : '0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for rf_wb_arbiter: table-driven vectors, hand sequences for the
// scoreboard / x0 / forwarding cases, then randomized traffic compared with a
// behavioural model.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;

  rf_wb_if #(.DW(DW), .AW(AW)) bus ();

`ifdef RF_WB_FORWARD_EN
  logic [AW-1:0] rd_ad1, rd_ad2;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
`endif

  rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef RF_WB_FORWARD_EN
    ,
    .rd_ad1    (rd_ad1),
    .rd_ad2    (rd_ad2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          hold;
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] adata;
    logic          mv;
    logic [AW-1:0] mrd;
    logic [DW-1:0] mdata;
    logic          iv;
    logic [AW-1:0] ird;
  } vin_t;

  typedef struct {
    vin_t          in;
    logic          exp_ar;
    logic          exp_mr;
    logic          exp_we;
    logic          chk_ad;
    logic [AW-1:0] exp_ad;
    logic [DW-1:0] exp_wd;
  } row_t;

  int n_vec = 0;
  int n_err = 0;

  // Sampled readies of the last applied cycle
  logic got_ar, got_mr;

  // Behavioural model: who went last, which registers are outstanding, what
  // the write port shows.
  bit            m_last_was_mem;
  bit            m_pend [32];
  bit            m_err;
  bit            m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  bit            m_ar, m_mr;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic model_reset();
    m_last_was_mem = 1'b1;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
    m_we  = 1'b0;
    m_ad  = '0;
    m_wd  = '0;
  endtask

  // Advance the model by one clock edge for inputs v.
  task automatic model_step(input vin_t v);
    int            who;   // 0 none, 1 alu, 2 mem
    logic [AW-1:0] rd;
    logic [DW-1:0] dat;
    m_ar = 1'b0;
    m_mr = 1'b0;
    if (!v.rst && !v.hold) begin
      if (v.av && v.mv) begin
        m_ar = m_last_was_mem;
        m_mr = !m_last_was_mem;
      end else begin
        m_ar = v.av;
        m_mr = v.mv;
      end
    end
    if (v.rst) begin
      model_reset();
      return;
    end
    who = m_ar ? 1 : (m_mr ? 2 : 0);
    rd  = (who == 2) ? v.mrd : v.ard;
    dat = (who == 2) ? v.mdata : v.adata;
    m_we = 1'b0;
    if (who != 0) begin
      m_last_was_mem = (who == 2);
      if (rd != 0) begin
        m_we = 1'b1;
        m_ad = rd;
        m_wd = dat;
        if (!m_pend[rd] && !(v.iv && v.ird == rd)) m_err = 1'b1;
        m_pend[rd] = 1'b0;
      end
    end
    if (v.iv && v.ird != 0) m_pend[v.ird] = 1'b1;
  endtask

  // Drive one cycle of inputs after the falling edge, sample readies, let the
  // rising edge happen and return #1 after it.
  task automatic apply(input vin_t v);
    @(negedge clk);
    rst           = v.rst;
    bus.hold      = v.hold;
    bus.alu_valid = v.av;
    bus.alu_rd    = v.ard;
    bus.alu_data  = v.adata;
    bus.mem_valid = v.mv;
    bus.mem_rd    = v.mrd;
    bus.mem_data  = v.mdata;
    bus.iss_valid = v.iv;
    bus.iss_rd    = v.ird;
    #1;
    got_ar = bus.alu_ready;
    got_mr = bus.mem_ready;
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  function automatic vin_t mk(input logic r, input logic h,
                              input logic av, input int ard, input logic [DW-1:0] ad,
                              input logic mv, input int mrd, input logic [DW-1:0] md,
                              input logic iv, input int ird);
    vin_t v;
    v.rst = r;  v.hold = h;
    v.av = av;  v.ard = AW'(ard); v.adata = ad;
    v.mv = mv;  v.mrd = AW'(mrd); v.mdata = md;
    v.iv = iv;  v.ird = AW'(ird);
    return v;
  endfunction

  row_t tbl[$];

  task automatic add_row(input vin_t v, input logic ar, input logic mr, input logic we,
                         input logic chk, input int ad, input logic [DW-1:0] wd);
    row_t r;
    r.in = v; r.exp_ar = ar; r.exp_mr = mr; r.exp_we = we;
    r.chk_ad = chk; r.exp_ad = AW'(ad); r.exp_wd = wd;
    tbl.push_back(r);
  endtask

  vin_t          idle_v, v;
  logic [DW-1:0] a1, b2, d9;

  initial begin
    rst = 1'b1;
    bus.hold = 0; bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
`ifdef RF_WB_FORWARD_EN
    rd_ad1 = 0; rd_ad2 = 0;
`endif
    model_reset();
    idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    a1 = 32'hAAAA_0001;
    b2 = 32'hBBBB_0002;
    d9 = 32'h9999_0009;

    // ---------------- table-driven vectors ----------------
    // Reset with both requesters valid, then strict alternation ALU first.
    add_row(mk(1, 0, 1, 3, a1, 1, 4, b2, 0, 0), 0, 0, 0, 1, 0, 0);
    add_row(mk(0, 0, 1, 3, a1, 1, 4, b2, 0, 0), 1, 0, 1, 1, 3, a1);
    add_row(mk(0, 0, 1, 3, a1, 1, 4, b2, 0, 0), 0, 1, 1, 1, 4, b2);
    add_row(mk(0, 0, 1, 3, a1, 1, 4, b2, 0, 0), 1, 0, 1, 1, 3, a1);
    add_row(mk(0, 0, 1, 3, a1, 1, 4, b2, 0, 0), 0, 1, 1, 1, 4, b2);
    // Single requester streaming, no bubbles.
    for (int r = 5; r <= 8; r++)
      add_row(mk(0, 0, 0, 0, 0, 1, r, 32'h5000_0000 + r, 0, 0), 0, 1, 1, 1, r, 32'h5000_0000 + r);
    // Idle: regwrite drops, ad3/wd3 hold.
    add_row(idle_v, 0, 0, 0, 1, 8, 32'h5000_0008);
    // hold for 3 cycles with an ALU request pending.
    for (int k = 0; k < 3; k++)
      add_row(mk(0, 1, 1, 9, d9, 0, 0, 0, 0, 0), 0, 0, 0, 1, 8, 32'h5000_0008);
    add_row(mk(0, 0, 1, 9, d9, 0, 0, 0, 0, 0), 1, 0, 1, 1, 9, d9);
    add_row(idle_v, 0, 0, 0, 1, 9, d9);

    foreach (tbl[i]) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d alu_ready", i), got_ar, tbl[i].exp_ar);
      check($sformatf("tbl%0d mem_ready", i), got_mr, tbl[i].exp_mr);
      check($sformatf("tbl%0d regwrite", i), bus.regwrite, tbl[i].exp_we);
      if (tbl[i].chk_ad) begin
        check($sformatf("tbl%0d ad3", i), bus.ad3, tbl[i].exp_ad);
        check($sformatf("tbl%0d wd3", i), bus.wd3, tbl[i].exp_wd);
      end
    end

    // Write port stays quiet when a hold arrives right after a transfer, but
    // the registered write itself still shows.
    apply(mk(0, 0, 1, 10, 32'h0A, 0, 0, 0, 0, 0));
    check("hold_pre regwrite", bus.regwrite, 1);
    apply(mk(0, 1, 1, 11, 32'h0B, 0, 0, 0, 0, 0));
    check("hold_mid ready", got_ar, 0);
    check("hold_mid regwrite", bus.regwrite, 0);
    apply(mk(0, 0, 1, 11, 32'h0B, 0, 0, 0, 0, 0));
    check("hold_post ad3", bus.ad3, 11);

    // ---------------- x0 write ----------------
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0));
    check("x0 alu_ready", got_ar, 1);
    check("x0 regwrite", bus.regwrite, 0);
    check("x0 pending0", bus.pending[0], 0);
    check("x0 sb_err", bus.sb_err, 0);
    apply(idle_v);
    check("x0 regwrite later", bus.regwrite, 0);

    // ---------------- scoreboard ----------------
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12));
    check("sb issue pend12", bus.pending[12], 1);
    apply(mk(0, 0, 1, 12, 32'hC0DE_0012, 0, 0, 0, 1, 12));
    check("sb reissue ready", got_ar, 1);
    check("sb reissue pend12", bus.pending[12], 1);
    check("sb reissue ad3", bus.ad3, 12);
    check("sb reissue err", bus.sb_err, 0);
    apply(mk(0, 0, 0, 0, 0, 1, 12, 32'hC0DE_0013, 0, 0));
    check("sb clear pend12", bus.pending[12], 0);
    check("sb clear err", bus.sb_err, 0);
    apply(mk(0, 0, 1, 12, 32'hC0DE_0014, 0, 0, 0, 0, 0));
    check("sb stray err", bus.sb_err, 1);
    apply(idle_v);
    apply(idle_v);
    check("sb sticky err", bus.sb_err, 1);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("sb rst err", bus.sb_err, 0);
    check("sb rst pending", bus.pending, 0);

`ifdef RF_WB_FORWARD_EN
    // ---------------- forwarding ----------------
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
    rd_ad1 = 7;
    rd_ad2 = 0;
    apply(mk(0, 0, 1, 7, 32'h0000_1234, 0, 0, 0, 0, 0));
    check("fwd1 hit", fwd1_hit, 1);
    check("fwd1 data", fwd1_data, 32'h1234);
    check("fwd2 hit", fwd2_hit, 0);
    check("fwd2 data", fwd2_data, 0);
    apply(idle_v);
    check("fwd1 idle hit", fwd1_hit, 0);
    check("fwd1 idle data", fwd1_data, 0);
`endif

    // ---------------- randomized traffic vs model ----------------
    begin
      logic          a_v, m_v;
      logic [AW-1:0] a_rd, m_rd;
      logic [DW-1:0] a_d, m_d;
      a_v = 0; m_v = 0; a_rd = 0; m_rd = 0; a_d = 0; m_d = 0;
      for (int c = 0; c < 600; c++) begin
        // Requesters keep rd/data stable while valid until accepted.
        if (!a_v && ($urandom_range(0, 1) == 1)) begin
          a_v = 1; a_rd = AW'($urandom_range(0, 31)); a_d = $urandom;
        end
        if (!m_v && ($urandom_range(0, 1) == 1)) begin
          m_v = 1; m_rd = AW'($urandom_range(0, 31)); m_d = $urandom;
        end
        v = mk(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0),
               a_v, int'(a_rd), a_d, m_v, int'(m_rd), m_d,
               ($urandom_range(0, 2) == 0), $urandom_range(0, 31));
        apply(v);
        check("rnd alu_ready", got_ar, m_ar);
        check("rnd mem_ready", got_mr, m_mr);
        check("rnd regwrite", bus.regwrite, m_we);
        if (m_we) begin
          check("rnd ad3", bus.ad3, m_ad);
          check("rnd wd3", bus.wd3, m_wd);
        end
        check("rnd pending", bus.pending, model_pending());
        check("rnd sb_err", bus.sb_err, m_err);
        if (got_ar) a_v = 0;
        if (got_mr) m_v = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
